// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: retires RADIX_BITS multiplier bits per cycle
// into a single 2*WIDTH accumulator, with valid/ready handshakes on both sides.
module seq_shift_add_mul #(
  parameter int WIDTH      = 24,
  parameter int RADIX_BITS = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);

  if ((WIDTH % RADIX_BITS) != 0) begin : g_width_check
    $error("seq_shift_add_mul: WIDTH must be a multiple of RADIX_BITS");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_shr;

  // mcand*mplier[RADIX_BITS-1:0] as a sum of shifted copies; mcand never
  // exceeds 2*WIDTH bits of significance, so no carry is lost.
  always_comb begin
    partial = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
  end

  assign acc_sum    = acc_q + partial;
  assign mplier_shr = mplier_q >> RADIX_BITS;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = CNT_W'(STEPS);
          if ((EARLY_EXIT != 0) && (b == '0)) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q - CNT_W'(1);
        if ((cnt_q == CNT_W'(1)) || ((EARLY_EXIT != 0) && (mplier_shr == '0))) begin
          product_d = acc_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed and randomised checks of seq_shift_add_mul across several radix/early-exit builds.
module tb_seq_shift_add_mul;

  localparam int W = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_ready = 1'b0;
  logic           in_valid  [4];
  logic           in_ready  [4];
  logic           out_valid [4];
  logic           busy      [4];
  logic [2*W-1:0] product   [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 0: K=1  1: K=4  2: K=1 with early exit  3: K=3
  seq_shift_add_mul #(.WIDTH(W), .RADIX_BITS(1), .EARLY_EXIT(0)) dut_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a), .b(b),
    .out_valid(out_valid[0]), .out_ready(out_ready), .product(product[0]), .busy(busy[0]));
  seq_shift_add_mul #(.WIDTH(W), .RADIX_BITS(4), .EARLY_EXIT(0)) dut_k4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a), .b(b),
    .out_valid(out_valid[1]), .out_ready(out_ready), .product(product[1]), .busy(busy[1]));
  seq_shift_add_mul #(.WIDTH(W), .RADIX_BITS(1), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a), .b(b),
    .out_valid(out_valid[2]), .out_ready(out_ready), .product(product[2]), .busy(busy[2]));
  seq_shift_add_mul #(.WIDTH(W), .RADIX_BITS(3), .EARLY_EXIT(0)) dut_k3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .a(a), .b(b),
    .out_valid(out_valid[3]), .out_ready(out_ready), .product(product[3]), .busy(busy[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation on DUT sel. Latency = edges after the accepting edge
  // until out_valid is seen. During the stall in_valid is pulsed with junk operands.
  task automatic run_op(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int stall, output logic [2*W-1:0] prod, output int lat);
    int guard;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid[sel] = 1'b1;
    guard = 0;
    while (!in_ready[sel] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    lat = 0;
    while (!out_valid[sel] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product[sel];
    for (int i = 0; i < stall; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      in_valid[sel] = i[0];
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid[sel], 1'b1);
      check("stall_in_ready", in_ready[sel], 1'b0);
      check("stall_product", product[sel], prod);
    end
    in_valid[sel] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid[sel], 1'b0);
    check("release_busy", busy[sel], 1'b0);
    check("release_product_held", product[sel], prod);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] p;
    int             lat;
    int             exp_lat;
    logic [W-1:0]   av, bv;
    int             sels [4];

    for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_low", in_ready[0], 1'b0);
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_in_ready", in_ready[i], 1'b1);
      check("post_rst_product", product[i], 48'h0);
    end

    // b=0 without early exit still takes the full run
    run_op(0, 24'h00_0005, 24'h00_0000, 0, p, lat);
    check("k1_b0_product", p, 48'h0);
    check("k1_b0_latency", lat, 24);

    // Max operands
    run_op(0, 24'hFF_FFFF, 24'hFF_FFFF, 2, p, lat);
    check("k1_max_product", p, 48'hFFFF_FE00_0001);
    check("k1_max_latency", lat, 24);

    run_op(1, 24'h00_0003, 24'h00_0005, 0, p, lat);
    check("k4_3x5_product", p, 48'd15);
    check("k4_3x5_latency", lat, 6);

    run_op(2, 24'h12_3456, 24'h00_0001, 0, p, lat);
    check("ee_b1_product", p, 48'h12_3456);
    check("ee_b1_latency", lat, 1);
    run_op(2, 24'h12_3456, 24'h00_0000, 0, p, lat);
    check("ee_b0_product", p, 48'h0);
    check("ee_b0_latency", lat, 0);

    // Ten-cycle stall in DONE with in_valid pulses
    run_op(1, 24'hAB_CDEF, 24'h00_0010, 10, p, lat);
    check("k4_stall_product", p, 48'h0AB_CDEF0);
    check("k4_stall_latency", lat, 6);

    // Reset on RUN cycle 10 aborts the operation
    @(negedge clk);
    a = 24'd100;
    b = 24'd200;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", busy[0], 1'b0);
    check("abort_out_valid", out_valid[0], 1'b0);
    check("abort_product", product[0], 48'h0);
    check("abort_in_ready", in_ready[0], 1'b1);
    run_op(0, 24'd7, 24'd9, 1, p, lat);
    check("after_abort_product", p, 48'd63);
    check("after_abort_latency", lat, 24);

    // Reset in DONE wins over out_ready and in_valid
    @(negedge clk);
    a = 24'd11;
    b = 24'd13;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;
    check("done_before_rst", out_valid[1], 1'b1);
    check("done_product_before_rst", product[1], 48'd143);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_done_out_valid", out_valid[1], 1'b0);
    check("rst_done_busy", busy[1], 1'b0);
    check("rst_done_product", product[1], 48'h0);
    in_valid[1] = 1'b0;

    // Randomised operands and stalls on every build
    sels = '{0, 1, 3, 2};
    foreach (sels[s]) begin
      for (int n = 0; n < 40; n++) begin
        av = W'($urandom);
        bv = W'($urandom);
        if (n == 0) bv = '0;
        if (n == 1) begin av = '1; bv = '1; end
        if (n % 5 == 2) bv = bv >> $urandom_range(0, W - 1);
        run_op(sels[s], av, bv, $urandom_range(0, 3), p, lat);
        case (sels[s])
          0:       exp_lat = 24;
          1:       exp_lat = 6;
          3:       exp_lat = 8;
          default: exp_lat = (bv == '0) ? 0 : $clog2(int'(bv) + 1);
        endcase
        check("rand_product", p, {{W{1'b0}}, av} * {{W{1'b0}}, bv});
        check("rand_latency", lat, exp_lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
